// File: rtl/matmul_sequencer.sv
// Control sequencer for an N x N matrix product on a single shared MAC datapath:
// issues operand reads, drives the datapath enables, writes each C element and tracks overflow.
module matmul_sequencer #(
  parameter int MAT_DIM    = 4,
  parameter int IDX_WIDTH  = 2,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  rd_en,
  output logic [ADDR_WIDTH-1:0] addr_A,
  output logic [ADDR_WIDTH-1:0] addr_B,
  output logic                  en_Mux,
  output logic                  en_PPReg,
  output logic                  en_FDReg,
  input  logic                  resultIsInvalid,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic                  overflow
);

  localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(MAT_DIM - 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

  state_t               state, state_d;
  logic [IDX_WIDTH-1:0] row_p0, col_p0, k_p0;
  logic [IDX_WIDTH-1:0] row_d, col_d, k_d;
  logic [IDX_WIDTH-1:0] row_p1, col_p1;
  logic                 drain_p0, drain_d;
  logic                 issue_d, busy_d, done_d, clr_ovf;

  function automatic logic [ADDR_WIDTH-1:0] flat_addr(input logic [IDX_WIDTH-1:0] major,
                                                      input logic [IDX_WIDTH-1:0] minor);
    return ADDR_WIDTH'(32'(major) * 32'(MAT_DIM) + 32'(minor));
  endfunction

  always_comb begin
    state_d  = state;
    row_d    = row_p0;
    col_d    = col_p0;
    k_d      = k_p0;
    drain_d  = drain_p0;
    issue_d  = 1'b0;
    busy_d   = busy;
    done_d   = 1'b0;
    clr_ovf  = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_d = S_ISSUE;
          row_d   = '0;
          col_d   = '0;
          k_d     = '0;
          issue_d = 1'b1;
          busy_d  = 1'b1;
          clr_ovf = 1'b1;
        end
      end
      S_ISSUE: begin
        // Counters name the step presented this cycle; the last step stops issuing.
        if (row_p0 == LAST_IDX && col_p0 == LAST_IDX && k_p0 == LAST_IDX) begin
          state_d = S_DRAIN;
          drain_d = 1'b0;
        end else begin
          issue_d = 1'b1;
          if (k_p0 == LAST_IDX) begin
            k_d = '0;
            if (col_p0 == LAST_IDX) begin
              col_d = '0;
              row_d = row_p0 + 1'b1;
            end else begin
              col_d = col_p0 + 1'b1;
            end
          end else begin
            k_d = k_p0 + 1'b1;
          end
        end
      end
      S_DRAIN: begin
        if (drain_p0) begin
          state_d = S_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          drain_d = 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Stage 0: issue (FSM, loop counters, operand read addresses)
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= S_IDLE;
      row_p0   <= '0;
      col_p0   <= '0;
      k_p0     <= '0;
      drain_p0 <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      rd_en    <= 1'b0;
      addr_A   <= '0;
      addr_B   <= '0;
    end else begin
      state    <= state_d;
      row_p0   <= row_d;
      col_p0   <= col_d;
      k_p0     <= k_d;
      drain_p0 <= drain_d;
      busy     <= busy_d;
      done     <= done_d;
      rd_en    <= issue_d;
      addr_A   <= flat_addr(row_d, k_d);
      addr_B   <= flat_addr(k_d, col_d);
    end
  end

  // Stage 1: compute (operands arrive from RAM, MAC enables)
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      en_PPReg <= 1'b0;
      en_Mux   <= 1'b0;
      en_FDReg <= 1'b0;
      row_p1   <= '0;
      col_p1   <= '0;
    end else begin
      en_PPReg <= rd_en;
      en_Mux   <= rd_en && (k_p0 != '0);
      en_FDReg <= rd_en && (k_p0 == LAST_IDX);
      row_p1   <= row_p0;
      col_p1   <= col_p0;
    end
  end

  // Stage 2: result write and sticky overflow collection
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_en    <= 1'b0;
      wr_addr  <= '0;
      overflow <= 1'b0;
    end else begin
      wr_en <= en_FDReg;
      if (en_FDReg) begin
        wr_addr <= flat_addr(row_p1, col_p1);
      end
      if (clr_ovf) begin
        overflow <= 1'b0;
      end else if (wr_en) begin
        overflow <= overflow | resultIsInvalid;
      end
    end
  end

endmodule

// File: doc/matmul_sequencer.md
Name: matmul_sequencer

Overview:
Control FSM that runs a square matrix product C = A x B on the shared multiply-accumulate datapath, one MAC per cycle. It issues operand read addresses to the A/B operand RAMs (1-cycle synchronous read). It drives the datapath enables en_Mux, en_PPReg and en_FDReg, and issues a result write for every element of C. It also collects the datapath's resultIsInvalid flag into a sticky overflow status and exposes a start/busy/done handshake to the host.

Parameters:
MAT_DIM, 4, matrix dimension N (N x N operands); legal 2..16
IDX_WIDTH, 2, width of row/col/k counters = clog2(MAT_DIM)
ADDR_WIDTH, 4, operand/result address width = 2*IDX_WIDTH

Ports:
clk  input  1  system clock, all state on rising edge
reset_n  input  1  asynchronous active-low reset
start  input  1  run request, sampled only in IDLE
busy  output  1  high while a run is in progress
done  output  1  one-cycle pulse when the run completes
rd_en  output  1  operand RAM read strobe
addr_A  output  ADDR_WIDTH  A read address = row*N + k
addr_B  output  ADDR_WIDTH  B read address = k*N + col
en_Mux  output  1  datapath: 0 adds zero (first term), 1 adds partial-product register
en_PPReg  output  1  datapath partial-product register load
en_FDReg  output  1  datapath final-data register load
resultIsInvalid  input  1  datapath overflow flag for the current final-data register content
wr_en  output  1  result RAM write strobe
wr_addr  output  ADDR_WIDTH  result address = row*N + col
overflow  output  1  sticky: some C element of this run had resultIsInvalid=1

Behaviour:
- Reset (async, reset_n=0): state=IDLE; all counters 0; busy=done=rd_en=en_Mux=en_PPReg=en_FDReg=wr_en=overflow=0; addr_A=addr_B=wr_addr=0. Reset mid-run aborts immediately with no further writes.
- All outputs are registered.
- States:
  - IDLE: start=1 moves to ISSUE; clears overflow and counters; busy=1 from next cycle.
  - ISSUE: rd_en=1 every cycle.
  - DRAIN: waits for the last write.
  - DONE: done=1 for one cycle, busy=0, then IDLE.
- Loop order: row outer, col middle, k inner. Each step increments k. At k=N-1, k wraps to 0 and col increments. At col=N-1 with k=N-1, col wraps and row increments. The step with row=col=k=N-1 is the last issue; next state is DRAIN.
- Pipeline (stage 0 issue, 1 compute, 2 write):
  - Stage 1 (one cycle after an issue):
    - en_PPReg=1.
    - en_Mux=(k_s1!=0).
    - en_FDReg=(k_s1==N-1).
  - Stage 2: wr_en=1 one cycle after each en_FDReg=1. wr_addr=row_s2*N+col_s2. The result RAM captures outData at this edge.
- Overflow: on each wr_en cycle, overflow <= overflow | resultIsInvalid. It holds after done until the next accepted start.
- Timing: start sampled high at edge 0 gives:
  - rd_en in cycles 1..N^3.
  - en_PPReg in cycles 2..N^3+1.
  - wr_en in cycles N+2, 2N+2, ..., N^3+2 (N^2 writes).
  - DRAIN covers cycles N^3+1..N^3+2.
  - done=1 in cycle N^3+3 with busy=0.
- busy is high in cycles 1..N^3+2.
- start while busy or during the DONE cycle is ignored; no queuing. start held high continuously re-launches from IDLE the cycle after DONE.
- No stall input: operand and result RAMs are single-cycle and always ready.

Test Plan:
1. Basic product: N=2, A=[[1,2],[3,4]], B=[[5,6],[7,8]], pulse start. Required: wr_en exactly 4 times with wr_addr 0,1,2,3 and data 19,22,43,50. done in cycle 11, busy high in cycles 1..10, overflow=0.
2. Enable sequencing: N=4, identity A, B[i][j]=i*4+j. Required: en_Mux=0 exactly at every 4th en_PPReg. en_FDReg coincides with k=3. Result equals B. 16 writes; done in cycle 67.
3. Overflow sticky: N=2, A all 20, B all 20 (element 800, datapath flags invalid). Required: resultIsInvalid seen on the writes and overflow=1 after done. A following run with A=B=identity clears overflow at its start and ends with overflow=0.
4. Start ignored while busy: during run 1, pulse start in cycles 3 and 10. Required: a single run, exactly N^2 writes, one done pulse.
5. Reset mid-run: N=4, drop reset_n asynchronously at cycle 20. Required: all outputs 0 immediately with no wr_en afterwards. A start after release gives a full correct run from row=col=k=0.
6. Back-to-back: start held high. Required: second run's first rd_en occurs 2 cycles after the first run's done (IDLE then ISSUE), and every address sequence repeats exactly.
